// File: rtl/mem_defs_pkg.sv
// Shared definitions for the MEM-stage store controller: store-type encodings,
// FSM state encoding, word geometry and the misalignment predicate.
package mem_defs_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_WIDTH = 8 * WORD_BYTES;
    localparam int unsigned OFF_WIDTH  = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        STORE_SB  = 2'd0,
        STORE_SH  = 2'd1,
        STORE_SW  = 2'd2,
        STORE_RSV = 2'd3
    } store_type_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_MRG  = 2'd2,
        S_WR   = 2'd3
    } state_t;

    // True when the store cannot be performed at its natural alignment.
    function automatic logic is_misaligned(store_type_t t, logic [OFF_WIDTH-1:0] off);
        return ((t == STORE_SH) && off[0]) || ((t == STORE_SW) && (off != '0));
    endfunction

endpackage

// File: rtl/mem_store_rmw_if.sv
// Store request + data memory bus of the MEM-stage store controller.
//   slave  : controller side (accepts requests, drives the memory port)
//   master : pipeline / memory side
interface mem_store_rmw_if
    import mem_defs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    store_type_t           req_store_type;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  stall;
    logic                  done;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_re;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  misalign_err;

    modport slave (
        input  req_valid, req_store_type, req_addr, req_wdata, mem_rdata,
        output req_ready, stall, done, mem_addr, mem_re, mem_we, mem_wdata, misalign_err
    );

    modport master (
        output req_valid, req_store_type, req_addr, req_wdata, mem_rdata,
        input  req_ready, stall, done, mem_addr, mem_re, mem_we, mem_wdata, misalign_err
    );
endinterface

// File: rtl/store_byte_merge.sv
// Combinational little-endian merge of a sub-word store into a read word.
//   rdata      in  : word read from memory
//   wdata      in  : store data (SB uses [7:0], SH uses [15:0])
//   store_type in  : SB / SH / SW / reserved
//   byte_off   in  : byte offset addr[1:0] (SH looks at bit 1 only)
//   merged     out : word to write back
module store_byte_merge
    import mem_defs_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  store_type_t           store_type,
    input  logic [OFF_WIDTH-1:0]  byte_off,
    output logic [DATA_WIDTH-1:0] merged
);

    always_comb begin
        merged = rdata;
        case (store_type)
            STORE_SB: begin
                case (byte_off)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            STORE_SH: begin
                if (byte_off[1]) merged[31:16] = wdata[15:0];
                else             merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_store_rmw.sv
// MEM-stage store controller. SW (and reserved type) write directly; SB/SH do a
// read-modify-write on the single-port, 1-cycle-read data memory. Stalls the
// pipeline while a store is in flight.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_store_rmw_if.slave (request handshake + memory port)
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned SH/SW are accepted, do
// no memory access and raise a one-cycle misalign_err instead of done.
module mem_store_rmw
    import mem_defs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_store_rmw_if.slave   bus
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [OFF_WIDTH-1:0]  off_q;
    store_type_t           type_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  re_q;
    logic                  we_q;
    logic                  done_q;
    logic                  mis_q;
    logic                  trap_c;
    logic [DATA_WIDTH-1:0] merged_c;

    store_byte_merge u_merge (
        .rdata      (bus.mem_rdata),
        .wdata      (wdata_q),
        .store_type (type_q),
        .byte_off   (off_q),
        .merged     (merged_c)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_c = is_misaligned(bus.req_store_type, bus.req_addr[OFF_WIDTH-1:0]);
`else
    assign trap_c = 1'b0;
`endif

    // Store FSM; strobes default low and are set only for the cycle they apply to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            off_q       <= '0;
            type_q      <= STORE_SB;
            wdata_q     <= '0;
            mem_wdata_q <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            re_q   <= 1'b0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= {bus.req_addr[ADDR_WIDTH-1:OFF_WIDTH], OFF_WIDTH'(0)};
                        off_q   <= bus.req_addr[OFF_WIDTH-1:0];
                        type_q  <= bus.req_store_type;
                        wdata_q <= bus.req_wdata;
                        if (trap_c) begin
                            // Trap rides through WR with no strobe, so it still takes one cycle.
                            mis_q <= 1'b1;
                            state <= S_WR;
                        end else if (bus.req_store_type == STORE_SB ||
                                     bus.req_store_type == STORE_SH) begin
                            re_q  <= 1'b1;
                            state <= S_RD;
                        end else begin
                            mem_wdata_q <= bus.req_wdata;
                            we_q        <= 1'b1;
                            done_q      <= 1'b1;
                            state       <= S_WR;
                        end
                    end
                end
                S_RD:  state <= S_MRG;
                S_MRG: begin
                    // mem_rdata is valid this cycle, one cycle after the read strobe.
                    mem_wdata_q <= merged_c;
                    we_q        <= 1'b1;
                    done_q      <= 1'b1;
                    state       <= S_WR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = (state == S_IDLE);
    assign bus.stall        = (state != S_IDLE);
    assign bus.mem_addr     = addr_q;
    assign bus.mem_re       = re_q;
    // Reset cancels an in-flight write and its retirement in the same cycle.
    assign bus.mem_we       = we_q & ~rst;
    assign bus.done         = done_q & ~rst;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.misalign_err = mis_q;

endmodule
